// File: rtl/linear_layer_fifo_pkg.sv
// Shared definitions for the start-token / small-data SRL FIFO.
// The pointer type is a generous fixed-width signed integer; each FIFO
// instance narrows it to ADDR_WIDTH+1 bits and widens back for compares.
package linear_layer_fifo_pkg;

  localparam int PTR_MAX_W = 16;

  typedef logic signed [PTR_MAX_W-1:0] ptr_t;

  // All ones: truncating this to any pointer width still gives -1 (empty).
  localparam ptr_t PTR_EMPTY = '1;

  // Ceiling log2 for elaboration-time sizing checks.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/linear_layer_start_fifo_srl_if.sv
// Producer/consumer handshake bundle of the SRL FIFO.
// The FIFO itself connects through the slave modport; whatever drives the
// write side and drains the read side uses the master modport.
interface linear_layer_start_fifo_srl_if #(
  parameter int DATA_WIDTH = 1
);
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;

  modport slave (
    output if_full_n, if_empty_n, if_dout,
    input  if_write_ce, if_write, if_din, if_read_ce, if_read
  );

  modport master (
    input  if_full_n, if_empty_n, if_dout,
    output if_write_ce, if_write, if_din, if_read_ce, if_read
  );
endinterface

// File: rtl/linear_layer_fifo_srl_store.sv
// Shift-register storage: each write pushes din into entry 0 and moves
// every entry up by one; reads are an addressed combinational mux.
// Contents are deliberately not reset so the array maps onto SRL primitives.
module linear_layer_fifo_srl_store #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Shift the whole chain by one position on every accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Addresses past DEPTH only occur while empty, where dout is don't-care.
  assign dout = (int'(addr) < DEPTH) ? mem_q[addr] : '0;

endmodule

// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token / small-data FIFO built on shift-register storage.
// Tracks occupancy with a signed pointer (-1 = empty, k = k+1 words) that
// always addresses the oldest word, and produces registered empty_n/full_n.
// Optional macro LINEAR_LAYER_FIFO_OUTPUT_REG_EN adds a one-entry output
// register after the SRL head (2-cycle first-word latency, capacity DEPTH+1).
module linear_layer_start_fifo_srl
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input logic                     clk,
  input logic                     ap_rst_n,
  linear_layer_start_fifo_srl_if.slave fifo
);

  typedef logic signed [ADDR_WIDTH:0] ptr_w_t;

  localparam ptr_w_t PTR_RESET   = ptr_w_t'(PTR_EMPTY);
  // For DEPTH == 1 this is -1, so the full transition fires from empty.
  localparam ptr_t   PTR_FULL_AT = ptr_t'(DEPTH - 2);
  localparam ptr_t   PTR_LAST    = ptr_t'(0);

  if ((DEPTH < 1) || (clog2(DEPTH) > ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must be >= 1 and fit in ADDR_WIDTH address bits");
  end

  ptr_w_t                out_ptr_q;
  logic                  srl_empty_n_q;
  logic                  srl_full_n_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  srl_pop;
  logic [DATA_WIDTH-1:0] srl_head;

  assign wr_acc = fifo.if_write & fifo.if_write_ce & srl_full_n_q;
  assign rd_acc = fifo.if_read & fifo.if_read_ce & fifo.if_empty_n;

`ifdef LINEAR_LAYER_FIFO_OUTPUT_REG_EN
  logic                  out_vld_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  // The SRL head moves into the output register whenever that register is
  // free or being drained this cycle.
  assign srl_pop = srl_empty_n_q & (~out_vld_q | rd_acc);

  // Output register valid bit: loading wins over draining.
  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      out_vld_q <= 1'b0;
    end else if (srl_pop) begin
      out_vld_q <= 1'b1;
    end else if (rd_acc) begin
      out_vld_q <= 1'b0;
    end
  end

  // Output register data, not reset: only meaningful while out_vld_q is set.
  always_ff @(posedge clk) begin
    if (srl_pop) out_data_q <= srl_head;
  end

  assign fifo.if_dout    = out_data_q;
  assign fifo.if_empty_n = out_vld_q;
`else
  assign srl_pop         = rd_acc;
  assign fifo.if_dout    = srl_head;
  assign fifo.if_empty_n = srl_empty_n_q;
`endif

  assign fifo.if_full_n = srl_full_n_q;

  // Occupancy pointer and flags move together; push+pop leaves them as is.
  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      out_ptr_q     <= PTR_RESET;
      srl_empty_n_q <= 1'b0;
      srl_full_n_q  <= 1'b1;
    end else begin
      case ({wr_acc, srl_pop})
        2'b10: begin
          out_ptr_q     <= out_ptr_q + ptr_w_t'(1);
          srl_empty_n_q <= 1'b1;
          if (ptr_t'(out_ptr_q) == PTR_FULL_AT) srl_full_n_q <= 1'b0;
        end
        2'b01: begin
          out_ptr_q    <= out_ptr_q - ptr_w_t'(1);
          srl_full_n_q <= 1'b1;
          if (ptr_t'(out_ptr_q) == PTR_LAST) srl_empty_n_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  linear_layer_fifo_srl_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk  (clk),
    .we   (wr_acc),
    .addr (out_ptr_q[ADDR_WIDTH-1:0]),
    .din  (fifo.if_din),
    .dout (srl_head)
  );

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Bench for linear_layer_start_fifo_srl: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_linear_layer_start_fifo_srl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic ap_rst_n;

  always #5 clk = ~clk;

  linear_layer_start_fifo_srl_if #(.DATA_WIDTH(DW)) fifo_if ();

  linear_layer_start_fifo_srl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .ap_rst_n (ap_rst_n),
    .fifo     (fifo_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: words held by the FIFO, oldest first.
  logic [DW-1:0] q [$];
`ifdef LINEAR_LAYER_FIFO_OUTPUT_REG_EN
  bit            out_v = 1'b0;
  logic [DW-1:0] out_d = '0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model on the edge.
  task automatic step(input bit rst_n, input bit w, input bit wce, input logic [DW-1:0] din,
                      input bit r, input bit rce);
    bit wr_ok, rd_ok;
    ap_rst_n            = rst_n;
    fifo_if.if_write    = w;
    fifo_if.if_write_ce = wce;
    fifo_if.if_din      = din;
    fifo_if.if_read     = r;
    fifo_if.if_read_ce  = rce;
    @(negedge clk);
`ifdef LINEAR_LAYER_FIFO_OUTPUT_REG_EN
    check("empty_n", 32'(fifo_if.if_empty_n), 32'(out_v));
    check("full_n", 32'(fifo_if.if_full_n), 32'(q.size() < DEPTH));
    if (out_v) check("dout", 32'(fifo_if.if_dout), 32'(out_d));
`else
    check("empty_n", 32'(fifo_if.if_empty_n), 32'(q.size() > 0));
    check("full_n", 32'(fifo_if.if_full_n), 32'(q.size() < DEPTH));
    if (q.size() > 0) check("dout", 32'(fifo_if.if_dout), 32'(q[0]));
`endif
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
`ifdef LINEAR_LAYER_FIFO_OUTPUT_REG_EN
      out_v = 1'b0;
`endif
      $display("cyc %0d: reset", cyc);
    end else begin
      wr_ok = w && wce && (q.size() < DEPTH);
`ifdef LINEAR_LAYER_FIFO_OUTPUT_REG_EN
      rd_ok = r && rce && out_v;
      if (rd_ok) $display("cyc %0d: rd 0x%0h", cyc, out_d);
      if ((!out_v || rd_ok) && q.size() > 0) begin
        out_d = q.pop_front();
        out_v = 1'b1;
      end else if (rd_ok) begin
        out_v = 1'b0;
      end
`else
      rd_ok = r && rce && (q.size() > 0);
      if (rd_ok) $display("cyc %0d: rd 0x%0h", cyc, q.pop_front());
`endif
      if (wr_ok) begin
        q.push_back(din);
        $display("cyc %0d: wr 0x%0h", cyc, din);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic rdwr(input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b1, d, 1'b1, 1'b1);
  endtask

  initial begin
    bit            rst_b, w_b, wce_b, r_b, rce_b;
    int            wr_bias;
    logic [DW-1:0] d;

    ap_rst_n            = 1'b0;
    fifo_if.if_write    = 1'b0;
    fifo_if.if_write_ce = 1'b0;
    fifo_if.if_din      = '0;
    fifo_if.if_read     = 1'b0;
    fifo_if.if_read_ce  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then idle with a read pending on the empty FIFO.
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Fill to full, drop a fifth write, drain in order.
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    wr(8'h55);
    repeat (4) rd();
    idle();

    // Simultaneous read+write at occupancy 2.
    wr(8'hA0); wr(8'hA1);
    repeat (3) rdwr(8'hA2);
    repeat (2) rd();
    idle();

    // Read+write when empty, then read+write when full.
    rdwr(8'h5A);
    idle();
    wr(8'h5B); wr(8'h5C); wr(8'h5D);
    rdwr(8'h5E);
    idle();
    repeat (4) rd();
    idle();

    // ce low on each side, then reset with three words stored.
    wr(8'hC1); wr(8'hC2); wr(8'hC3);
    step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle();
    idle();

`ifdef LINEAR_LAYER_FIFO_OUTPUT_REG_EN
    // Two-cycle first-word latency and DEPTH+1 capacity.
    wr(8'h77);
    idle();
    idle();
    rd();
    idle();
    for (int i = 0; i < 6; i++) wr(8'(8'h80 + i));
    check("accepted_before_full", 32'(q.size() + int'(out_v)), 32'(DEPTH + 1));
    repeat (6) rd();
    idle();
`endif

    // Randomized traffic with alternating fill/drain bias and rare resets.
    wr_bias = 50;
    for (int c = 0; c < 800; c++) begin
      if (c % 40 == 0) wr_bias = $urandom_range(20, 80);
      rst_b = ($urandom_range(99) != 0);
      w_b   = ($urandom_range(99) < wr_bias);
      wce_b = ($urandom_range(9) != 0);
      r_b   = ($urandom_range(99) >= wr_bias);
      rce_b = ($urandom_range(9) != 0);
      d     = 8'($urandom);
      step(rst_b, w_b, wce_b, d, r_b, rce_b);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
